// File: rtl/multi_sel_gen_pkg.sv
// Shared types and helpers for the multiply-select generator.
// Holds the FSM state type, the default coefficient set and coefficient extraction.
package multi_sel_gen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Coefficients 1, 3, 7, 8 packed low-index first.
    localparam logic [15:0] DEF_COEFS    = 16'h8731;
    localparam int          COEF_VEC_MAX = 256;
    localparam int          COEF_MAX_W   = 32;

    function automatic logic [COEF_MAX_W-1:0] get_coef(
        input logic [COEF_VEC_MAX-1:0] vec,
        input int unsigned             k,
        input int unsigned             w
    );
        logic [COEF_MAX_W-1:0] mask;
        mask = (w >= COEF_MAX_W) ? '1 : ((COEF_MAX_W'(1) << w) - COEF_MAX_W'(1));
        return COEF_MAX_W'(vec >> (k * w)) & mask;
    endfunction

endpackage

// File: rtl/multi_sel_gen_if.sv
// Operand-in / product-out bundle of the multiply-select generator.
// slave = generator side, master = producer/consumer side.
interface multi_sel_gen_if #(
    parameter int DATA_W   = 8,
    parameter int NUM_COEF = 4,
    parameter int OUT_W    = 12
);
    localparam int IDX_W = (NUM_COEF > 1) ? $clog2(NUM_COEF) : 1;

    logic              free_run;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] d;
    logic              input_grant;
    logic              out_valid;
    logic [IDX_W-1:0]  out_idx;
    logic [OUT_W-1:0]  out;

    modport slave (
        input  free_run, in_valid, d,
        output in_ready, input_grant, out_valid, out_idx, out
    );

    modport master (
        output free_run, in_valid, d,
        input  in_ready, input_grant, out_valid, out_idx, out
    );
endinterface

// File: rtl/multi_sel_gen_mul.sv
// Purpose: unsigned DATA_W x COEF_W multiply reduced to OUT_W bits.
// Latency: combinational. Backpressure: none. MULTI_SEL_GEN_SAT_EN saturates instead of truncating.
module multi_sel_gen_mul #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 4,
    parameter int OUT_W  = 12
) (
    input  logic [DATA_W-1:0] a,
    input  logic [COEF_W-1:0] c,
    output logic [OUT_W-1:0]  p
);
    localparam int FULL_W = DATA_W + COEF_W;

    logic [FULL_W-1:0] full;
    logic              ovf;

    assign full = FULL_W'(a) * FULL_W'(c);

`ifdef MULTI_SEL_GEN_SAT_EN
    assign ovf = (FULL_W > OUT_W) && ((full >> OUT_W) != '0);
`else
    assign ovf = 1'b0;
`endif

    assign p = ovf ? '1 : OUT_W'(full);

endmodule

// File: rtl/multi_sel_gen.sv
// Purpose: samples an operand and streams operand*COEFS[k], k=0..NUM_COEF-1, one per cycle.
// Latency: first product one cycle after capture. Backpressure: in_ready only at sample points; output not stallable.
// MULTI_SEL_GEN_SAT_EN selects saturating product reduction in the multiplier.
module multi_sel_gen
    import multi_sel_gen_pkg::*;
#(
    parameter int                          DATA_W   = 8,
    parameter int                          NUM_COEF = 4,
    parameter int                          COEF_W   = 4,
    parameter logic [NUM_COEF*COEF_W-1:0]  COEFS    = DEF_COEFS,
    parameter int                          OUT_W    = DATA_W + COEF_W
) (
    input  logic               clk,
    input  logic               rst,
    multi_sel_gen_if.slave     bus
);
    localparam int               IDX_W = (NUM_COEF > 1) ? $clog2(NUM_COEF) : 1;
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_COEF - 1);

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] d_reg;
    logic [OUT_W-1:0]  out_reg;
    logic              grant_reg;

    logic              sample;
    logic              capture;
    logic [IDX_W-1:0]  sel_idx;
    logic [DATA_W-1:0] mul_a;
    logic [COEF_W-1:0] coef_sel;
    logic [OUT_W-1:0]  prod;

    // The multiplier always computes the product that will be shown next cycle.
    always_comb begin
        sample   = (state == IDLE) || (idx == LAST);
        capture  = sample && (bus.free_run || bus.in_valid);
        sel_idx  = capture ? '0 : idx + IDX_W'(1);
        mul_a    = capture ? bus.d : d_reg;
        coef_sel = COEF_W'(get_coef(COEF_VEC_MAX'(COEFS), 32'(sel_idx), 32'(COEF_W)));
    end

    multi_sel_gen_mul #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .OUT_W  (OUT_W)
    ) u_mul (
        .a (mul_a),
        .c (coef_sel),
        .p (prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            d_reg     <= '0;
            out_reg   <= '0;
            grant_reg <= 1'b0;
        end else if (capture) begin
            state     <= RUN;
            idx       <= '0;
            d_reg     <= bus.d;
            out_reg   <= prod;
            grant_reg <= 1'b1;
        end else if (state == RUN && idx != LAST) begin
            idx       <= sel_idx;
            out_reg   <= prod;
            grant_reg <= 1'b0;
        end else begin
            state     <= IDLE;
            idx       <= '0;
            out_reg   <= '0;
            grant_reg <= 1'b0;
        end
    end

    assign bus.in_ready    = !rst && sample;
    assign bus.out_valid   = (state == RUN);
    assign bus.out_idx     = idx;
    assign bus.out         = out_reg;
    assign bus.input_grant = grant_reg;

endmodule

// File: tb/tb_multi_sel_gen.sv
// Randomized and directed bench for multi_sel_gen against a queue-based product model.
module tb_multi_sel_gen;
    localparam int DATA_W   = 8;
    localparam int NUM_COEF = 4;
    localparam int COEF_W   = 4;
    localparam int OUT_W    = 12;
    localparam int OUT_W2   = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multi_sel_gen_if #(.DATA_W(DATA_W), .NUM_COEF(NUM_COEF), .OUT_W(OUT_W))  bus ();
    multi_sel_gen_if #(.DATA_W(DATA_W), .NUM_COEF(NUM_COEF), .OUT_W(OUT_W2)) bus2 ();

    multi_sel_gen #(
        .DATA_W(DATA_W), .NUM_COEF(NUM_COEF), .COEF_W(COEF_W),
        .COEFS(16'h8731), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    multi_sel_gen #(
        .DATA_W(DATA_W), .NUM_COEF(NUM_COEF), .COEF_W(COEF_W),
        .COEFS(16'h8731), .OUT_W(OUT_W2)
    ) dut_narrow (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    int coef [NUM_COEF] = '{1, 3, 7, 8};

    typedef struct {
        int val;
        int idx;
        bit grant;
    } exp_t;

    exp_t q[$];
    exp_t shown;
    bit   shown_vld;
    int   obs_out;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int reduce10(input int p);
`ifdef MULTI_SEL_GEN_SAT_EN
        return (p >= 1024) ? 1023 : p;
`else
        return p % 1024;
`endif
    endfunction

    // An accepted operand becomes NUM_COEF queued products; the queue drains one per cycle.
    function automatic void model_step(input bit r, input bit fr, input bit v, input int dv);
        if (r) begin
            q.delete();
        end else if (q.size() == 0 && (fr || v)) begin
            for (int k = 0; k < NUM_COEF; k++)
                q.push_back('{val: dv * coef[k], idx: k, grant: (k == 0)});
        end
        if (!r && q.size() > 0) begin
            shown     = q.pop_front();
            shown_vld = 1'b1;
        end else begin
            shown     = '{val: 0, idx: 0, grant: 1'b0};
            shown_vld = 1'b0;
        end
    endfunction

    task automatic cycle(input bit r, input bit fr, input bit v, input int dv);
        rst          = r;
        bus.free_run = fr;
        bus.in_valid = v;
        bus.d        = DATA_W'(dv);
        #1;
        chk("in_ready", 32'(bus.in_ready), 32'(!r && q.size() == 0));
        @(posedge clk);
        model_step(r, fr, v, dv);
        @(negedge clk);
        chk("out_valid", 32'(bus.out_valid), 32'(shown_vld));
        chk("out", 32'(bus.out), shown.val);
        chk("out_idx", 32'(bus.out_idx), shown.idx);
        chk("input_grant", 32'(bus.input_grant), 32'(shown.grant));
        obs_out = int'(bus.out);
    endtask

    int hs_exp [8] = '{7, 21, 49, 56, 129, 387, 903, 1032};
    int fr_exp [5] = '{143, 429, 1001, 1144, 143};

    initial begin
        bus2.free_run = 1'b1;
        bus2.in_valid = 1'b0;
        bus2.d        = 8'd143;
        shown         = '{val: 0, idx: 0, grant: 1'b0};
        shown_vld     = 1'b0;
        @(negedge clk);

        cycle(1, 1, 0, 143);
        cycle(1, 1, 0, 143);

        // Free-running, constant operand.
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 0, 143);
            chk("fr143", obs_out, fr_exp[i]);
        end
        for (int i = 0; i < 7; i++) cycle(0, 1, 0, 143);

        // Free-running with the operand changing every cycle.
        for (int i = 0; i < 12; i++) begin
            int dv;
            dv = (i % 3 == 0) ? 7 : ((i % 3 == 1) ? 6 : 128);
            cycle(0, 1, 0, dv);
        end

        // Drain to IDLE, then back-to-back handshake operands.
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            cycle(0, 0, 1, (i < 4) ? 7 : 129);
            chk("hs_b2b", obs_out, hs_exp[i]);
        end
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0);

        // Single handshake pulse.
        cycle(0, 0, 1, 255);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 11);
        chk("pulse_last", obs_out, 2040);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 11);

        // Reset while idx 2 is on the output.
        cycle(0, 0, 1, 50);
        cycle(0, 0, 0, 50);
        cycle(0, 0, 0, 50);
        chk("pre_rst_idx", 32'(bus.out_idx), 2);
        cycle(1, 0, 0, 50);
        cycle(0, 0, 1, 60);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 60);

        // Randomized mixed traffic.
        for (int blk = 0; blk < 25; blk++) begin
            bit fr;
            fr = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < 16; i++)
                cycle($urandom_range(0, 40) == 0, fr, $urandom_range(0, 1) == 1,
                      int'($urandom_range(0, 255)));
        end

        // Narrow-output instance, free-running with d=143.
        cycle(1, 1, 0, 143);
        for (int k = 1; k <= 8; k++) begin
            cycle(0, 1, 0, 143);
            chk("narrow_idx", 32'(bus2.out_idx), (k - 1) % NUM_COEF);
            chk("narrow_out", 32'(bus2.out), reduce10(143 * coef[(k - 1) % NUM_COEF]));
            if (k == 3) chk("narrow_idx2", 32'(bus2.out), 1001);
`ifdef MULTI_SEL_GEN_SAT_EN
            if (k == 4) chk("narrow_idx3", 32'(bus2.out), 1023);
`else
            if (k == 4) chk("narrow_idx3", 32'(bus2.out), 120);
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multi_sel_gen.md
Name: multi_sel_gen

Overview:
- Parametrised successor to the fixed 4-step multiply-select block.
- Samples a DATA_W-bit operand, then emits the operand times each of NUM_COEF constant coefficients on successive cycles, one product per cycle.
- Adds two operating modes:
  - free-running: fixed sample cadence, as in the previous generation;
  - valid/ready handshake: back-to-back operands with no bubble.
- Sits in front of arithmetic datapaths that need a scaled-operand stream.

Parameters:
- DATA_W, 8, operand width.
- NUM_COEF, 4, number of coefficients per operand (≥2).
- COEF_W, 4, width of each coefficient.
- COEFS, 16'h8731, packed coefficient vector, NUM_COEF*COEF_W bits; coefficient k occupies bits [k*COEF_W +: COEF_W]. Default sequence is 1, 3, 7, 8.
- OUT_W, DATA_W+COEF_W, product output width (may be narrower than DATA_W+COEF_W).

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous reset, active-high.
- free_run, input, 1, 1 = free-running cadence; 0 = handshake mode.
- in_valid, input, 1, operand valid (ignored when free_run=1).
- in_ready, output, 1, block can accept an operand this cycle.
- d, input, DATA_W, operand.
- input_grant, output, 1, pulses with the first product of each operand.
- out_valid, output, 1, out holds a valid product.
- out_idx, output, $clog2(NUM_COEF), index of the coefficient applied to out.
- out, output, OUT_W, product d*COEFS[out_idx].

Behaviour:
- Reset: one clock and synchronous reset, active-high; names clk and rst.
  - While rst=1, at each clock edge: out=0, out_valid=0, out_idx=0, input_grant=0, FSM→IDLE, operand register=0.
  - in_ready=0 while rst=1.
- FSM states: IDLE, RUN; index counter idx runs 0..NUM_COEF-1.
- Sample point: sample = (state==IDLE) | (state==RUN & idx==NUM_COEF-1).
- in_ready = !rst & sample (combinational).
- Capture condition:
  - free_run=1: capture at every sample point, unconditionally.
  - free_run=0: capture when in_valid & in_ready.
- Capture effect: register d; state→RUN; idx→0.
- Latency: one cycle. The cycle after capture has out_valid=1, out_idx=0, out=d*COEFS[0], input_grant=1.
- Following cycles: idx increments by 1 each cycle; out=d_reg*COEFS[idx]; input_grant=0.
- At idx==NUM_COEF-1:
  - If a capture occurs, the next cycle starts the new operand at idx 0, with no bubble.
  - Otherwise state→IDLE and out_valid=0 next cycle; out, out_idx and input_grant return to 0.
- Free-running mode is always in RUN after the first post-reset cycle.
  - A new operand is sampled every NUM_COEF cycles.
  - input_grant is high 1 of every NUM_COEF cycles.
- free_run is observed only at sample points. A change mid-sequence does not disturb the current operand.
- d is captured only at a capture edge. Changes to d between captures do not affect out.
- Arithmetic is unsigned. The full product is DATA_W+COEF_W bits; out takes its low OUT_W bits unless the optional feature is enabled.
- Reset asserted mid-sequence aborts the sequence. The first cycle after reset deasserts is IDLE with in_ready=1.
- in_valid held high in handshake mode yields continuous products, with input_grant every NUM_COEF cycles.

Optional Feature:
- Macro: MULTI_SEL_GEN_SAT_EN.
- Defined: if the full product ≥ 2^OUT_W, out = all-ones (2^OUT_W - 1).
- Undefined: out = product mod 2^OUT_W (plain truncation).
- The feature has no effect when OUT_W ≥ DATA_W+COEF_W.

Decomposition:
- Package multi_sel_gen_pkg holds:
  - state enum type (IDLE, RUN);
  - default coefficient constant 16'h8731;
  - helper function extracting coefficient k from the packed vector.
- Sub-module multi_sel_gen_mul: combinational DATA_W × COEF_W unsigned multiply, with output width reduction (saturate or truncate per macro). It is instantiated once; the FSM/counter stays in the top module.

Test Plan:
- Reset then free_run=1, d=143 (defaults): out sequence 143, 429, 1001, 1144 with out_idx 0..3. input_grant is high only on the 143 cycle. The sequence repeats on each 4-cycle sample.
- Free run, d changes 7→6→128 mid-sequence: products follow only the d value held at each sample point; mid-sequence values are never observed on out.
- Handshake mode, in_valid held high with d=7 then d=129: products 7, 21, 49, 56, 129, 387, 903, 1032 back-to-back. in_ready pulses at idx 3; no bubble between operands.
- Handshake mode, single in_valid pulse with d=255: 4 valid products ending at 2040. out_valid=0 on the next cycle. in_ready=1 from the cycle after the last product until the next in_valid.
- rst=1 at idx 2 of an operand: next cycle out=0, out_valid=0, input_grant=0. After rst=0, in_ready=1 and a fresh operand starts at idx 0.
- OUT_W=10, d=143:
  - With MULTI_SEL_GEN_SAT_EN defined: the idx 3 product is 1023.
  - Without it: the idx 3 product is 120.
  - The idx 2 product is 1001 in both builds.
